// File: rtl/bus_pkg.sv
// Shared bus constants: default widths, default two-slave map,
// and a helper that pulls one window slice out of a packed vector.
package bus_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int MAX_SLV = 16;
    localparam int MAX_AW  = 64;
    localparam int VEC_W   = MAX_SLV * MAX_AW;

    localparam logic [15:0] SLV0_BASE = 16'h0000;
    localparam logic [15:0] SLV0_MASK = 16'hF800;
    localparam logic [15:0] SLV1_BASE = 16'h7000;
    localparam logic [15:0] SLV1_MASK = 16'hFE00;

    function automatic logic [MAX_AW-1:0] slv_slice(
        input logic [VEC_W-1:0] vec,
        input int               idx,
        input int               aw
    );
        logic [VEC_W-1:0] w_sh;
        w_sh = vec >> (idx * aw);
        return w_sh[MAX_AW-1:0] & ~({MAX_AW{1'b1}} << aw);
    endfunction

endpackage

// File: rtl/bus_addr_match.sv
// One slave window comparator: hit when the masked address equals the base.
module bus_addr_match #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_mask,
    output logic              o_hit
);

    assign o_hit = ((i_addr & i_mask) == i_base);

endmodule

// File: rtl/bus_addr_dec.sv
// N-slave address decoder with registered read-data return,
// decode-error pulse, sticky error address and saturating error count.
module bus_addr_dec #(
    parameter int                      ADDR_W    = bus_pkg::ADDR_W,
    parameter int                      DATA_W    = bus_pkg::DATA_W,
    parameter int                      N_SLV     = 2,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE  = {bus_pkg::SLV1_BASE,
                                                    bus_pkg::SLV0_BASE},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK  = {bus_pkg::SLV1_MASK,
                                                    bus_pkg::SLV0_MASK},
    parameter int                      ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    m_req,
    input  logic                    m_wr,
    input  logic [ADDR_W-1:0]       m_addr,
    output logic [N_SLV-1:0]        s_sel,
    input  logic [N_SLV*DATA_W-1:0] s_dout,
    output logic [DATA_W-1:0]       m_din,
    output logic                    m_rvalid,
    output logic                    dec_err,
    output logic [ADDR_W-1:0]       err_addr,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    input  logic                    err_clr
);

    localparam int                  P_VEC_W    = bus_pkg::VEC_W;
    localparam logic [P_VEC_W-1:0]  P_BASE_VEC = P_VEC_W'(SLV_BASE);
    localparam logic [P_VEC_W-1:0]  P_MASK_VEC = P_VEC_W'(SLV_MASK);
    localparam logic [ERR_CNT_W-1:0] P_CNT_MAX = {ERR_CNT_W{1'b1}};

    logic [N_SLV-1:0]     w_hit;
    logic [N_SLV-1:0]     w_pri;
    logic                 w_any;
    logic                 w_rd_fire;
    logic                 w_err;
    logic                 w_capture;
    logic [DATA_W-1:0]    w_din;

    logic [N_SLV-1:0]     r_rd_sel;
    logic                 r_rvalid;
    logic                 r_dec_err;
    logic [ADDR_W-1:0]    r_err_addr;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_sticky;

    for (genvar i = 0; i < N_SLV; i++) begin : g_match
        localparam logic [ADDR_W-1:0] P_BASE =
            ADDR_W'(bus_pkg::slv_slice(P_BASE_VEC, i, ADDR_W));
        localparam logic [ADDR_W-1:0] P_MASK =
            ADDR_W'(bus_pkg::slv_slice(P_MASK_VEC, i, ADDR_W));

        bus_addr_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .i_addr (m_addr),
            .i_base (P_BASE),
            .i_mask (P_MASK),
            .o_hit  (w_hit[i])
        );
    end

    // Descending scan so the lowest-index hit is the one left standing.
    always_comb begin
        w_pri = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_pri    = '0;
                w_pri[i] = 1'b1;
            end
        end
    end

    assign w_any     = |w_hit;
    assign s_sel     = {N_SLV{m_req}} & w_pri;
    assign w_rd_fire = m_req & ~m_wr & w_any;
    assign w_err     = m_req & ~w_any;
    assign w_capture = w_err & (~r_sticky | err_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_sel <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rd_sel <= w_rd_fire ? s_sel : '0;
            r_rvalid <= w_rd_fire;
        end
    end

    always_comb begin
        w_din = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_rd_sel[i]) begin
                w_din = w_din | s_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dec_err <= 1'b0;
        end else begin
            r_dec_err <= w_err;
        end
    end

    // A new error in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_err) begin
            if (err_clr) begin
                r_err_cnt <= ERR_CNT_W'(1);
            end else if (r_err_cnt != P_CNT_MAX) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_addr <= '0;
            r_sticky   <= 1'b0;
        end else if (w_capture) begin
            r_err_addr <= m_addr;
            r_sticky   <= 1'b1;
        end else if (err_clr) begin
            r_sticky   <= 1'b0;
        end
    end

    assign m_din    = w_din;
    assign m_rvalid = r_rvalid;
    assign dec_err  = r_dec_err;
    assign err_addr = r_err_addr;
    assign err_cnt  = r_err_cnt;

endmodule
